// File: rtl/alu_shift_seq.sv
// Sequential shifter: SLL/SLLI/SLR/SLRI, one bit per SHIFT cycle, with a valid/ready request and response.
// Define ALU_SHIFT_SEQ_FAST_EN to shift up to 4 bits per SHIFT cycle instead.
package simple_processor_pkg;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    FUNC_SLL  = 4'h4,
    FUNC_SLLI = 4'h5,
    FUNC_SLR  = 4'h6,
    FUNC_SLRI = 4'h7
  } func_e;
endpackage

module alu_shift_seq #(
  parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            func_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [5:0]            imm_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SHAMT_W-1:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic                  left_q, left_d;
  logic                  err_q, err_d;

  logic [SHAMT_W-1:0]    dec_shamt;
  logic                  dec_left;
  logic                  dec_ok;
  logic [SHAMT_W-1:0]    step;

  // Only the low SHAMT_W bits of the shift-amount sources matter.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^{rs2_data_i, imm_i};

  always_comb begin
    dec_shamt = '0;
    dec_left  = 1'b0;
    dec_ok    = 1'b1;
    case (func_i)
      simple_processor_pkg::FUNC_SLL: begin
        dec_shamt = rs2_data_i[SHAMT_W-1:0];
        dec_left  = 1'b1;
      end
      simple_processor_pkg::FUNC_SLLI: begin
        dec_shamt = imm_i[SHAMT_W-1:0];
        dec_left  = 1'b1;
      end
      simple_processor_pkg::FUNC_SLR: begin
        dec_shamt = rs2_data_i[SHAMT_W-1:0];
      end
      simple_processor_pkg::FUNC_SLRI: begin
        dec_shamt = imm_i[SHAMT_W-1:0];
      end
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef ALU_SHIFT_SEQ_FAST_EN
  always_comb begin
    step = (count_q > SHAMT_W'(4)) ? SHAMT_W'(4) : count_q;
  end
`else
  always_comb begin
    step = SHAMT_W'(1);
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    left_d  = left_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          left_d = dec_left;
          if (!dec_ok) begin
            err_d   = 1'b1;
            work_d  = '0;
            count_d = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            work_d  = rs1_data_i;
            count_d = dec_shamt;
            state_d = (dec_shamt == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = left_q ? (work_q << step) : (work_q >> step);
        count_d = count_q - step;
        if (count_q == step) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          work_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign result_o    = rsp_valid_o ? work_q : '0;
  assign err_o       = rsp_valid_o & err_q;

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 Parameter DATA_WIDTH, default simple_processor_pkg::DATA_WIDTH, operand/result width.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 arst_ni  input  1  asynchronous active-low reset.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept a request.
REQ-007 func_i  input  4  operation code: SLL, SLLI, SLR, SLRI from simple_processor_pkg.
REQ-008 rs1_data_i  input  DATA_WIDTH  operand to shift.
REQ-009 rs2_data_i  input  DATA_WIDTH  register shift amount (SLL/SLR).
REQ-010 imm_i  input  6  immediate shift amount (SLLI/SLRI).
REQ-011 rsp_valid_o  output  1  result available.
REQ-012 rsp_ready_i  input  1  consumer accepts result.
REQ-013 result_o  output  DATA_WIDTH  shifted result.
REQ-014 err_o  output  1  unsupported func_i; qualified by rsp_valid_o.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, SHIFT, DONE; req_ready_o SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid_i & req_ready_o at a posedge; func_i, rs1_data_i, rs2_data_i and imm_i SHALL be sampled only at accept and ignored otherwise.
REQ-018 shamt = rs2_data_i[SHAMT_W-1:0] for SLL/SLR, imm_i[SHAMT_W-1:0] for SLLI/SLRI; upper bits ignored.
REQ-019 SLL/SLLI: logical left shift, zero fill; SLR/SLRI: logical right shift, zero fill.
REQ-020 On accept: shamt==0 or unsupported func -> DONE; otherwise -> SHIFT with count=shamt and working register=rs1_data_i.
REQ-021 In SHIFT, each cycle: working register shifts by 1 bit, count decrements; at the edge where count goes 1->0, FSM -> DONE.
REQ-022 Latency: rsp_valid_o SHALL rise exactly shamt+1 cycles after the accept edge (1 cycle for shamt==0).
REQ-023 In DONE: rsp_valid_o=1; result_o and err_o SHALL be stable until rsp_ready_i=1, after which FSM -> IDLE on the same edge.
REQ-024 Unsupported func_i: result_o=0, err_o=1, latency 1 cycle.
REQ-025 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i; no new request is accepted in the DONE handshake cycle (minimum 1 idle cycle between jobs).
REQ-026 result_o SHALL read 0 outside DONE.

Reset
REQ-027 arst_ni low SHALL immediately force IDLE, count=0, working register=0, rsp_valid_o=0, result_o=0, err_o=0, busy_o=0, req_ready_o=1.
REQ-028 Reset mid-SHIFT or mid-DONE SHALL abort the job without a response; the first request after release SHALL execute normally.

Configuration
REQ-029 Macro ALU_SHIFT_SEQ_FAST_EN defined: SHIFT step = min(4, count) bits per cycle; latency = ceil(shamt/4)+1 cycles.
REQ-030 ALU_SHIFT_SEQ_FAST_EN undefined: 1 bit per cycle per REQ-021/REQ-022; function results SHALL be identical in both builds.

Verification (DATA_WIDTH=32)
REQ-031 SLLI, rs1=0x0000_0001, imm=4 -> result_o=0x0000_0010, err_o=0, rsp_valid_o 5 cycles after accept (fast: 2).
REQ-032 SLR, rs1=0x8000_0000, rs2=0xFFFF_FFE0 (shamt=0) -> result_o=0x8000_0000, latency 1.
REQ-033 SLL, rs1=0xFFFF_FFFF, rs2=31 -> result_o=0x8000_0000, latency 32 (fast: 9).
REQ-034 SLRI, rs1=0xF000_0000, imm=8, rsp_ready_i held 0 for 10 cycles -> rsp_valid_o=1, result_o=0x00F0_0000 stable, req_ready_o=0; after handshake IDLE and req_ready_o=1 next cycle.
REQ-035 SLL, shamt=20, arst_ni pulsed low 3 cycles after accept -> rsp_valid_o=0, busy_o=0, result_o=0 immediately; following SLLI rs1=0x3, imm=1 -> 0x6.
REQ-036 func_i=4'hF -> err_o=1, result_o=0, rsp_valid_o 1 cycle after accept.
